ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  It is the send-side partner of the keyboard receiver and shares the same ps2_clk/ps2_data pins.
//  The lines are open-drain: this block only ever pulls a line low; the pad ties *_oe to a pull-down.
//  The receiver must ignore the line while busy is high.

---
 rtl/ps2_host_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs,
//   0xFF reset) to a keyboard over the shared open-drain ps2_clk/ps2_data pins.
//   This block only ever pulls a line low; the pad converts *_oe into a pull-down.
//   A receiver sharing the pins should ignore the line while o_busy is high.
//
//   Transfer sequence:
//     IDLE -> INHIBIT (hold clk low) -> REQ (data low = start bit, device clocks
//     data/parity/stop out on its falling edges) -> ACK (device pulls data low
//     on the 11th edge) -> WAIT_IDLE (both lines back high) -> DONE pulse.
//     A missing ACK or an overall timeout produces an ERR pulse instead.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles ps2_clk is held low before the request.
//   TIMEOUT_CYCLES  max clk cycles from the request to the end of the transfer.
//
// Ports
//   i_clk           system clock
//   i_clrn          asynchronous active-low reset
//   i_tx_data[7:0]  command byte, sampled when i_tx_valid & o_tx_ready
//   i_tx_valid      request to send i_tx_data
//   o_tx_ready      high only in IDLE
//   o_busy          high in every state except IDLE
//   o_done          1-cycle pulse: byte sent and ACK seen
//   o_err           1-cycle pulse: no ACK or timeout
//   i_ps2_clk_in    raw ps2_clk pad level (asynchronous)
//   i_ps2_data_in   raw ps2_data pad level (asynchronous)
//   o_ps2_clk_oe    1 = pull ps2_clk low (registered)
//   o_ps2_data_oe   1 = pull ps2_data low (registered)
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_clrn,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int CNT_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [2:0]       r_clk_sync;
  logic [2:0]       r_data_sync;
  logic             w_fe;
  logic             w_clk_lvl;
  logic             w_data_lvl;

  logic [9:0]       r_sh;
  logic [9:0]       w_sh_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_next;
  logic [TMO_W-1:0] w_tmo_inc;
  logic             w_tmo_expired;
  logic [3:0]       r_bitn;
  logic [3:0]       w_bitn_next;

  logic             r_clk_oe;
  logic             w_clk_oe_next;
  logic             r_data_oe;
  logic             w_data_oe_next;

  // ---------------------------------------------------------------------------
  // 3-flop synchronisers. Bit 0 is the newest sample. They reset to 1 (idle
  // bus level) so releasing reset never fabricates a falling edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk_in};
      r_data_sync <= {r_data_sync[1:0], i_ps2_data_in};
    end
  end

  // Older sample high, newer sample low: one-cycle falling-edge pulse.
  assign w_fe       = (r_clk_sync[2:1] == 2'b10);
  assign w_clk_lvl  = r_clk_sync[1];
  assign w_data_lvl = r_data_sync[1];

  // Saturating timeout counter step; it can never wrap back to a small value.
  assign w_tmo_inc     = (r_tmo == TMO_MAX) ? r_tmo : (r_tmo + TMO_ONE);
  assign w_tmo_expired = (r_tmo >= TMO_LAST);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_bitn    <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sh      <= w_sh_next;
      r_cnt     <= w_cnt_next;
      r_tmo     <= w_tmo_next;
      r_bitn    <= w_bitn_next;
      r_clk_oe  <= w_clk_oe_next;
      r_data_oe <= w_data_oe_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and line-drive logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_sh_next      = r_sh;
    w_cnt_next     = r_cnt;
    w_tmo_next     = r_tmo;
    w_bitn_next    = r_bitn;
    w_data_oe_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_tx_valid) begin
          // {stop, odd parity, data}; the start bit is the REQ data pull-down.
          w_sh_next    = {1'b1, ~^i_tx_data, i_tx_data};
          w_cnt_next   = CNT_LOAD;
          w_state_next = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (r_cnt == '0) begin
          w_state_next   = S_REQ;
          w_bitn_next    = '0;
          w_tmo_next     = '0;
          w_data_oe_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end

      S_REQ: begin
        w_tmo_next     = w_tmo_inc;
        w_data_oe_next = r_data_oe;
        if (w_tmo_expired) begin
          w_state_next   = S_ERR;
          w_data_oe_next = 1'b0;
        end else if (w_fe) begin
          // The word is shifted right as it goes out, so sh[0] is always the
          // bit for the current edge (equivalent to indexing with bitn).
          // Shifting in ones keeps the line released once the word is spent.
          w_data_oe_next = ~r_sh[0];
          w_sh_next      = {1'b1, r_sh[9:1]};
          w_bitn_next    = r_bitn + 4'd1;
          if (r_bitn == 4'd9) begin
            w_state_next = S_ACK;
          end
        end
      end

      S_ACK: begin
        w_tmo_next = w_tmo_inc;
        if (w_tmo_expired) begin
          w_state_next = S_ERR;
        end else if (w_fe) begin
          // 11th edge: device holds data low to acknowledge.
          w_state_next = w_data_lvl ? S_ERR : S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        w_tmo_next = w_tmo_inc;
        if (w_tmo_expired) begin
          w_state_next = S_ERR;
        end else if (w_clk_lvl && w_data_lvl) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      S_ERR: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // clk is only ever pulled during the inhibit window.
    w_clk_oe_next = (w_state_next == S_INHIBIT);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_tx_ready    = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_err         = (r_state == S_ERR);
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Bench for ps2_host_tx with a behavioural PS/2 device on open-drain pads.
//   The device samples the start bit before its first clock, then one bit on
//   each rising edge, and optionally acknowledges on the 11th clock.
//   Expected frames are built from the byte: start 0, LSB-first data, odd
//   parity (1 when the byte has an even number of ones), stop 1.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH = 64;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       clk_oe;
  logic       data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Wired-AND open-drain bus: either side can pull a line low.
  wire pad_clk  = dev_clk & ~clk_oe;
  wire pad_data = dev_data & ~data_oe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk        (clk),
    .i_clrn       (clrn),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .i_ps2_clk_in (pad_clk),
    .i_ps2_data_in(pad_data),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_data_oe(data_oe)
  );

  // Cycle monitor: counts observed on the falling clock edge.
  int   cyc = 0;
  int   clk_oe_cyc = 0;
  int   data_oe_cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   accept_cnt = 0;
  int   last_done_cyc = -10;
  int   last_accept_cyc = -10;
  logic err_data_oe = 1'b0;
  logic err_clk_oe = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clk_oe)  clk_oe_cyc  <= clk_oe_cyc + 1;
    if (data_oe) data_oe_cyc <= data_oe_cyc + 1;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (err) begin
      err_cnt     <= err_cnt + 1;
      err_data_oe <= data_oe;
      err_clk_oe  <= clk_oe;
    end
    if (done && err) both_cnt <= both_cnt + 1;
    if (tx_valid && tx_ready) begin
      accept_cnt      <= accept_cnt + 1;
      last_accept_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference frame in device-sample order: bit 0 is the start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Behavioural device: waits for the request, clocks 11 times.
  task automatic device_xfer(input bit do_ack, input int half, output logic [10:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!(pad_data == 1'b0 && pad_clk == 1'b1 && busy) && n < INH + 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= INH + 200) begin
      failures++;
      $display("FAIL dev_request: request not seen after %0d cycles (need < %0d)", n, INH + 200);
      return;
    end
    repeat (half) tick();
    bits[0] = pad_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (half) tick();
      dev_clk = 1'b1;
      bits[k] = pad_data;
      repeat (half) tick();
    end
    if (do_ack) dev_data = 1'b0;
    dev_clk = 1'b0;
    repeat (half) tick();
    dev_clk = 1'b1;
    repeat (half) tick();
    dev_data = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!tx_ready && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL %s ready_wait: tx_ready=%0b after %0d cycles, need 1", name, tx_ready, n);
    end
  endtask

  // One complete transfer with the device model, checked against the model.
  task automatic run_xfer(input string name, input logic [7:0] d, input bit ack, input int half);
    logic [10:0] bits;
    logic [10:0] exp_bits;
    int done0, err0, oe0, both0, acc0;
    wait_ready({name, "_pre"});
    done0 = done_cnt; err0 = err_cnt; oe0 = clk_oe_cyc; both0 = both_cnt; acc0 = accept_cnt;
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    device_xfer(ack, half, bits);
    wait_ready(name);
    repeat (3) tick();
    exp_bits = frame_of(d);
    $display("xfer %s data=%02h ack=%0d half=%0d bits=%b", name, d, ack, half, bits);
    checks++;
    if (bits !== exp_bits) begin
      failures++;
      $display("FAIL %s frame: got %b need %b", name, bits, exp_bits);
    end
    checks++;
    if ((done_cnt - done0) !== (ack ? 1 : 0)) begin
      failures++;
      $display("FAIL %s done_cycles: got %0d need %0d", name, done_cnt - done0, ack ? 1 : 0);
    end
    checks++;
    if ((err_cnt - err0) !== (ack ? 0 : 1)) begin
      failures++;
      $display("FAIL %s err_cycles: got %0d need %0d", name, err_cnt - err0, ack ? 0 : 1);
    end
    checks++;
    if ((clk_oe_cyc - oe0) !== INH) begin
      failures++;
      $display("FAIL %s clk_oe_cycles: got %0d need %0d", name, clk_oe_cyc - oe0, INH);
    end
    checks++;
    if ((both_cnt - both0) !== 0 || (accept_cnt - acc0) !== 1) begin
      failures++;
      $display("FAIL %s overlap/accepts: both=%0d accepts=%0d need 0/1", name,
               both_cnt - both0, accept_cnt - acc0);
    end
    checks++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end_state: clk_oe=%0b data_oe=%0b ready=%0b busy=%0b need 0/0/1/0",
               name, clk_oe, data_oe, tx_ready, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: clk_oe=%0b data_oe=%0b done=%0b err=%0b need all 0",
               clk_oe, data_oe, done, err);
    end
    clrn = 1'b1;
    tick();
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%0b busy=%0b done=%0b err=%0b need 1/0/0/0",
               tx_ready, busy, done, err);
    end
    $display("xfer reset: ready=%0b busy=%0b", tx_ready, busy);
  endtask

  task automatic test_reset_mid();
    int n;
    // Reset while clk is being inhibited.
    tx_data = 8'h00; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    repeat (10) tick();
    checks++;
    if (clk_oe !== 1'b1) begin
      failures++;
      $display("FAIL mid_inhibit_pre: clk_oe=%0b need 1", clk_oe);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin
      failures++;
      $display("FAIL mid_inhibit_reset: clk_oe=%0b data_oe=%0b need 0/0", clk_oe, data_oe);
    end
    tick(); clrn = 1'b1; tick();
    // Reset after two data bits with data pulled low.
    tx_data = 8'h00; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    n = 0;
    while (data_oe !== 1'b1 && n < INH + 50) begin
      tick();
      n++;
    end
    repeat (15) tick();
    for (int k = 0; k < 2; k++) begin
      dev_clk = 1'b0; repeat (15) tick();
      dev_clk = 1'b1; repeat (15) tick();
    end
    checks++;
    if (data_oe !== 1'b1) begin
      failures++;
      $display("FAIL mid_bits_pre: data_oe=%0b need 1", data_oe);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin
      failures++;
      $display("FAIL mid_bits_reset: clk_oe=%0b data_oe=%0b need 0/0", clk_oe, data_oe);
    end
    tick(); clrn = 1'b1; tick();
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_bits_release: ready=%0b busy=%0b need 1/0", tx_ready, busy);
    end
    $display("xfer reset_mid: ready=%0b", tx_ready);
  endtask

  task automatic test_send_ed();
    logic [10:0] bits;
    logic [10:0] spec_bits;
    int oe0;
    spec_bits = 11'b11111011010;
    oe0 = clk_oe_cyc;
    wait_ready("ed_pre");
    tx_data = 8'hED; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    device_xfer(1'b1, 20, bits);
    wait_ready("ed");
    repeat (3) tick();
    $display("xfer send_ed data=ed bits=%b", bits);
    checks++;
    if (bits !== spec_bits) begin
      failures++;
      $display("FAIL ed_frame: got %b need %b", bits, spec_bits);
    end
    checks++;
    if ((clk_oe_cyc - oe0) !== INH) begin
      failures++;
      $display("FAIL ed_clk_oe_cycles: got %0d need %0d", clk_oe_cyc - oe0, INH);
    end
  endtask

  task automatic test_parity();
    run_xfer("parity_01", 8'h01, 1'b1, 18);
    run_xfer("parity_ff", 8'hFF, 1'b1, 22);
  endtask

  task automatic test_no_ack();
    run_xfer("no_ack", 8'hA5, 1'b0, 20);
    checks++;
    if (err_data_oe !== 1'b0 || err_clk_oe !== 1'b0) begin
      failures++;
      $display("FAIL no_ack_err_lines: data_oe=%0b clk_oe=%0b during err, need 0/0",
               err_data_oe, err_clk_oe);
    end
  endtask

  task automatic test_timeout();
    int n, d0, e0, oe0;
    wait_ready("timeout_pre");
    d0 = done_cnt; e0 = err_cnt; oe0 = data_oe_cyc;
    tx_data = 8'h3C; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    n = 0;
    while (!err && n < INH + TMO + 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    $display("xfer timeout data=3c cycles=%0d", n);
    checks++;
    if ((data_oe_cyc - oe0) !== TMO) begin
      failures++;
      $display("FAIL timeout_req_cycles: got %0d need %0d", data_oe_cyc - oe0, TMO);
    end
    checks++;
    if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
      failures++;
      $display("FAIL timeout_pulses: err=%0d done=%0d need 1/0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (err_data_oe !== 1'b0 || data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_end: data_oe_at_err=%0b data_oe=%0b ready=%0b need 0/0/1",
               err_data_oe, data_oe, tx_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         ack;
    int         half;
    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom);
      ack  = ($urandom % 4) != 0;
      half = int'($urandom_range(25, 12));
      run_xfer("random", d, ack, half);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a, b;
    logic [10:0] bits;
    int          n, acc0, dcyc, acyc;
    a = 8'($urandom);
    b = a ^ 8'h5A;
    wait_ready("b2b_pre");
    acc0 = accept_cnt;
    tx_data = a; tx_valid = 1'b1; tick();
    tx_data = b;
    device_xfer(1'b1, 20, bits);
    $display("xfer b2b_first data=%02h bits=%b", a, bits);
    checks++;
    if (bits !== frame_of(a)) begin
      failures++;
      $display("FAIL b2b_first_frame: got %b need %b", bits, frame_of(a));
    end
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_after_done: ready=%0b need 1", tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    tick();
    dcyc = last_done_cyc;
    acyc = last_accept_cyc;
    checks++;
    if (acyc !== dcyc + 1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_accept: accept_cyc=%0d done_cyc=%0d busy=%0b need done+1 and busy",
               acyc, dcyc, busy);
    end
    device_xfer(1'b1, 20, bits);
    wait_ready("b2b");
    repeat (3) tick();
    $display("xfer b2b_second data=%02h bits=%b", b, bits);
    checks++;
    if (bits !== frame_of(b) || (accept_cnt - acc0) !== 2) begin
      failures++;
      $display("FAIL b2b_second_frame: got %b accepts=%0d need %b accepts=2",
               bits, accept_cnt - acc0, frame_of(b));
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
